alu_issue_seq: RTL and testbench
================================

// Module: alu_issue_seq
// PURPOSE
//  Operand-fetch / issue / write-back sequencer directly upstream of the registered 8-bit ALU.
//  Holds a small register file, accepts 3-field register instructions over a valid/ready handshake,
//  drives the ALU operand/op inputs, captures the ALU's registered result and writes it back.
//  Also exposes an external load port for seeding registers and a result stream for observation.
// PARAMETERS
//  DATA_W   8   operand/result width (must match ALU width)
//  NREGS    4   register-file depth; must be a power of 2
//  RA_W     2   register address width = log2(NREGS)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       reset: synchronous, active-low
//  in_valid   in   1       instruction valid
//  in_ready   out  1       sequencer can accept an instruction this cycle
//  in_op      in   3       ALU function code (000 ADD,001 SUB,010 SHL,011 SHR,100 AND,101 OR,110 NOR,111 XOR)
//  in_rd      in   RA_W    destination register
//  in_rs1     in   RA_W    source A register
//  in_rs2     in   RA_W    source B register (SHL/SHR: bits [2:0] = shift amount)
//  ld_en      in   1       external register write request
//  ld_addr    in   RA_W    external write address
//  ld_data    in   DATA_W  external write data
//  alu_a      out  DATA_W  to ALU operand A (registered)
//  alu_b      out  DATA_W  to ALU operand B (registered)
//  alu_op     out  3       to ALU function select (registered)
//  alu_y      in   DATA_W  from ALU registered result
//  res_valid  out  1       one-cycle pulse: res_data/res_rd hold a completed result
//  res_data   out  DATA_W  written-back value
//  res_rd     out  RA_W    written-back register
//  dbg_addr   in   RA_W    debug read address
//  dbg_data   out  DATA_W  rf[dbg_addr], combinational
// BEHAVIOUR
//  - Reset: state=IDLE; all rf entries, alu_a, alu_b, alu_op, res_data, res_rd = 0; res_valid = 0.
//  - FSM: IDLE -> EXEC -> WB -> IDLE; one cycle per state; throughput 1 instr / 3 cycles.
//  - in_ready = (state==IDLE) && !ld_en. Accept = in_valid && in_ready at a rising edge.
//  - On accept: alu_a<=rf[in_rs1], alu_b<=rf[in_rs2], alu_op<=in_op; latch rd; state<=EXEC.
//  - EXEC: ALU evaluates held operands; ALU captures result at end of EXEC; state<=WB.
//  - WB: alu_y valid; at end of WB rf[rd]<=alu_y, res_data<=alu_y, res_rd<=rd, res_valid<=1
//    (pulse visible during the following IDLE cycle); state<=IDLE.
//  - Latency: accept edge to res_valid high = 3 clocks; rf updated at the same edge.
//  - alu_a/alu_b/alu_op hold their values outside EXEC (no return to 0).
//  - ld_en: honoured only in IDLE (rf[ld_addr]<=ld_data); blocks acceptance that cycle; ignored in EXEC/WB.
//  - No hazards: rf write precedes next accept, so back-to-back dependent instrs see the new value.
//  - rd==rs1/rs2 legal; operands already latched at accept.
//  - Arithmetic: all results modulo 2^DATA_W; no carry/flags consumed.
//  - rst_n low in any state: immediate return to IDLE next edge, in-flight instr discarded, no res_valid.
//  - in_valid while busy: held off (in_ready=0); instruction fields must stay stable until accepted.
// STRUCTURE
//  - Shared package: ALU opcode localparams (OP_ADD..OP_XOR), FSM state encoding (IDLE/EXEC/WB).
//  - Sub-module: seq_regfile (NREGS x DATA_W, 2 comb read + 1 debug read, 1 sync write port with
//    mux of ld/WB writers, sync reset clear).
//  - FSM, issue registers and result registers in the top module.
// TESTING (bench instantiates alu_issue_seq + ALU)
//  - Reset then dbg reads r0..r3 -> all 0x00; in_ready=1; res_valid=0.
//  - ld r1=0x05, r2=0x03; ADD r0,r1,r2 -> res_valid 3 clks after accept, res_data=0x08, res_rd=0.
//  - SUB r3,r2,r1 (0x03-0x05) -> 0xFE; ADD of 0xFF+0x01 -> 0x00 (wrap).
//  - Back-to-back: ADD r1,r1,r1 twice with r1=0x05 -> 0x0A then 0x14; in_ready low during EXEC/WB.
//  - ld r2=0x02, r1=0x81: SHL r0,r1,r2 -> 0x04; SHR r0,r1,r2 -> 0x20; NOR r0,r1,r1 -> 0x7E.
//  - ld_en and in_valid together in IDLE -> load performed, instr not accepted until next cycle;
//    rst_n low during EXEC -> no res_valid, rf cleared, IDLE.

Source files
------------

// File: rtl/alu_issue_seq_pkg.sv
// rtl/alu_issue_seq_pkg.sv - shared opcodes and FSM states for the ALU issue sequencer
package alu_issue_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_SHL = 3'b010;
   localparam logic [2:0] OP_SHR = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_NOR = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/seq_regfile.sv
// rtl/seq_regfile.sv - register file: two operand reads, one debug read, one shared write port
module seq_regfile #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 4,
   parameter int RA_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RA_W-1:0]   ra1,
   output logic [DATA_W-1:0] rd1,
   input  logic [RA_W-1:0]   ra2,
   output logic [DATA_W-1:0] rd2,
   input  logic [RA_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              ld_en,
   input  logic [RA_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              wb_en,
   input  logic [RA_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   logic [DATA_W-1:0] rf [NREGS];

   // Single write port; the top only raises ld_en in IDLE and wb_en in WB, so the
   // priority here never actually arbitrates, it just keeps one writer per edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            rf[i] <= '0;
         end
      end else if (wb_en) begin
         rf[wb_addr] <= wb_data;
      end else if (ld_en) begin
         rf[ld_addr] <= ld_data;
      end
   end

   assign rd1      = rf[ra1];
   assign rd2      = rf[ra2];
   assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - operand fetch / issue / write-back sequencer for the registered ALU
module alu_issue_seq
   import alu_issue_seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREGS  = 4,
   parameter int RA_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [RA_W-1:0]   in_rd,
   input  logic [RA_W-1:0]   in_rs1,
   input  logic [RA_W-1:0]   in_rs2,
   input  logic              ld_en,
   input  logic [RA_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_y,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic [RA_W-1:0]   res_rd,
   input  logic [RA_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   seq_state_t        state_q;
   seq_state_t        state_d;
   logic              accept;
   logic [RA_W-1:0]   rd_q;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic              rf_ld_en;
   logic              rf_wb_en;

   // External loads only land while idle; they are dropped in EXEC/WB.
   assign rf_ld_en = ld_en && (state_q == ST_IDLE);
   assign rf_wb_en = (state_q == ST_WB);

   seq_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .RA_W   (RA_W)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra1      (in_rs1),
      .rd1      (rs1_data),
      .ra2      (in_rs2),
      .rd2      (rs2_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .ld_en    (rf_ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .wb_en    (rf_wb_en),
      .wb_addr  (rd_q),
      .wb_data  (alu_y)
   );

   // Next state and handshake: a load in IDLE takes priority over accepting an instruction.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      accept   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = !ld_en;
            if (in_valid && !ld_en) begin
               accept  = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Issue registers: operands are fetched at accept and held until the next accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
         rd_q   <= '0;
      end else if (accept) begin
         alu_a  <= rs1_data;
         alu_b  <= rs2_data;
         alu_op <= in_op;
         rd_q   <= in_rd;
      end
   end

   // Result registers: res_valid pulses for the IDLE cycle after WB; data/rd hold afterwards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_rd    <= '0;
      end else begin
         res_valid <= rf_wb_en;
         if (rf_wb_en) begin
            res_data <= alu_y;
            res_rd   <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - directed self-checking bench for alu_issue_seq with a registered ALU model
module tb_alu_issue_seq;
   import alu_issue_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [1:0] in_rd, in_rs1, in_rs2;
   logic       ld_en;
   logic [1:0] ld_addr;
   logic [7:0] ld_data;
   logic [7:0] alu_a, alu_b, alu_y;
   logic [2:0] alu_op;
   logic       res_valid;
   logic [7:0] res_data;
   logic [1:0] res_rd;
   logic [1:0] dbg_addr;
   logic [7:0] dbg_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_y     (alu_y),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_rd    (res_rd),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   // Registered 8-bit ALU sitting downstream of the sequencer.
   always_ff @(posedge clk) begin
      case (alu_op)
         OP_ADD:  alu_y <= alu_a + alu_b;
         OP_SUB:  alu_y <= alu_a - alu_b;
         OP_SHL:  alu_y <= alu_a << alu_b[2:0];
         OP_SHR:  alu_y <= alu_a >> alu_b[2:0];
         OP_AND:  alu_y <= alu_a & alu_b;
         OP_OR:   alu_y <= alu_a | alu_b;
         OP_NOR:  alu_y <= ~(alu_a | alu_b);
         default: alu_y <= alu_a ^ alu_b;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
      dbg_addr = a;
      #1;
      check(tag, {24'd0, dbg_data}, {24'd0, exp});
   endtask

   task automatic do_ld(input logic [1:0] a, input logic [7:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      tick();
      ld_en   = 1'b0;
   endtask

   // Issue one instruction from IDLE and follow it through EXEC and WB to the result pulse.
   task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] exp);
      int wait_cnt;
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 10) begin
         tick();
         wait_cnt++;
      end
      check({tag, " ready_idle"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_op    = op;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
      tick();
      in_valid = 1'b0;
      check({tag, " exec_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, " exec_valid"}, {31'd0, res_valid}, 32'd0);
      check({tag, " exec_op"}, {29'd0, alu_op}, {29'd0, op});
      tick();
      check({tag, " wb_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, " wb_valid"}, {31'd0, res_valid}, 32'd0);
      tick();
      check({tag, " res_valid"}, {31'd0, res_valid}, 32'd1);
      check({tag, " res_data"}, {24'd0, res_data}, {24'd0, exp});
      check({tag, " res_rd"}, {30'd0, res_rd}, {30'd0, rd});
      check_reg({tag, " rf"}, rd, exp);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_op    = 3'd0;
      in_rd    = 2'd0;
      in_rs1   = 2'd0;
      in_rs2   = 2'd0;
      ld_en    = 1'b0;
      ld_addr  = 2'd0;
      ld_data  = 8'd0;
      dbg_addr = 2'd0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      for (int i = 0; i < 4; i++) begin
         check_reg($sformatf("reset r%0d", i), 2'(i), 8'h00);
      end
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset res_valid", {31'd0, res_valid}, 32'd0);
      check("reset alu_a", {24'd0, alu_a}, 32'd0);
      check("reset alu_op", {29'd0, alu_op}, 32'd0);

      // Basic arithmetic
      do_ld(2'd1, 8'h05);
      do_ld(2'd2, 8'h03);
      check_reg("ld r1", 2'd1, 8'h05);
      issue("add", OP_ADD, 2'd0, 2'd1, 2'd2, 8'h08);
      issue("sub", OP_SUB, 2'd3, 2'd2, 2'd1, 8'hFE);
      check("hold alu_op", {29'd0, alu_op}, {29'd0, OP_SUB});
      do_ld(2'd1, 8'hFF);
      do_ld(2'd2, 8'h01);
      issue("wrap", OP_ADD, 2'd0, 2'd1, 2'd2, 8'h00);

      // Back-to-back dependent instructions
      do_ld(2'd1, 8'h05);
      issue("dep1", OP_ADD, 2'd1, 2'd1, 2'd1, 8'h0A);
      issue("dep2", OP_ADD, 2'd1, 2'd1, 2'd1, 8'h14);

      // Shifts and logic
      do_ld(2'd2, 8'h02);
      do_ld(2'd1, 8'h81);
      issue("shl", OP_SHL, 2'd0, 2'd1, 2'd2, 8'h04);
      issue("shr", OP_SHR, 2'd0, 2'd1, 2'd2, 8'h20);
      issue("nor", OP_NOR, 2'd0, 2'd1, 2'd1, 8'h7E);
      tick();
      check("pulse one cycle", {31'd0, res_valid}, 32'd0);

      // Load and instruction together: load wins, instruction accepted next cycle
      ld_en    = 1'b1;
      ld_addr  = 2'd3;
      ld_data  = 8'h55;
      in_valid = 1'b1;
      in_op    = OP_ADD;
      in_rd    = 2'd0;
      in_rs1   = 2'd3;
      in_rs2   = 2'd3;
      #1;
      check("ld blocks ready", {31'd0, in_ready}, 32'd0);
      tick();
      ld_en = 1'b0;
      #1;
      check("still idle", {31'd0, in_ready}, 32'd1);
      check_reg("ld r3", 2'd3, 8'h55);
      tick();
      in_valid = 1'b0;
      check("accepted", {31'd0, in_ready}, 32'd0);
      // Load during EXEC is ignored
      ld_en   = 1'b1;
      ld_addr = 2'd2;
      ld_data = 8'h99;
      tick();
      ld_en = 1'b0;
      tick();
      check("late res_valid", {31'd0, res_valid}, 32'd1);
      check("late res_data", {24'd0, res_data}, 32'hAA);
      check_reg("exec ld ignored", 2'd2, 8'h02);

      // Reset during EXEC discards the instruction
      in_valid = 1'b1;
      in_op    = OP_ADD;
      in_rd    = 2'd0;
      in_rs1   = 2'd3;
      in_rs2   = 2'd3;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst idle", {31'd0, in_ready}, 32'd1);
      check("rst res_valid", {31'd0, res_valid}, 32'd0);
      check_reg("rst r3", 2'd3, 8'h00);
      tick();
      tick();
      check("rst no pulse", {31'd0, res_valid}, 32'd0);
      check_reg("rst r0", 2'd0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
